// File: rtl/rps_match_referee.sv
// Best-of-N rock/paper/scissors(/lizard/Spock) referee: locks one move per player, judges, scores.
// Define LIZARD_SPOCK_EN for the five-move game; otherwise only rock/paper/scissors are legal.
module rps_match_referee #(
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 4,
  parameter int MAX_ROUNDS    = 9,
  parameter int ROUND_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         p1_move,
  input  logic               p1_valid,
  input  logic [2:0]         p2_move,
  input  logic               p2_valid,
  input  logic               new_match,
  output logic               p1_held,
  output logic               p2_held,
  output logic [1:0]         move_err,
  output logic               round_p1_win,
  output logic               round_p2_win,
  output logic               round_tie,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               match_done,
  output logic [1:0]         match_winner
);

  // state  | meaning
  // WAIT   | collecting one move per player
  // JUDGE  | both moves locked; round resolved on exit edge
  // DONE   | match over, results held until new_match
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_JUDGE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] MV_ROCK     = 3'd1;
  localparam logic [2:0] MV_PAPER    = 3'd2;
  localparam logic [2:0] MV_SCISSORS = 3'd3;
`ifdef LIZARD_SPOCK_EN
  localparam logic [2:0] MV_LIZARD   = 3'd4;
  localparam logic [2:0] MV_SPOCK    = 3'd5;
`endif

  localparam logic [SCORE_W-1:0] WINS_L   = SCORE_W'(WINS_TO_MATCH);
  localparam logic [ROUND_W-1:0] ROUNDS_L = ROUND_W'(MAX_ROUNDS);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic move_legal(input logic [2:0] m);
`ifdef LIZARD_SPOCK_EN
    return (m >= MV_ROCK) && (m <= MV_SPOCK);
`else
    return (m >= MV_ROCK) && (m <= MV_SCISSORS);
`endif
  endfunction

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    logic r;
    r = 1'b0;
    case (a)
`ifdef LIZARD_SPOCK_EN
      MV_ROCK:     r = (b == MV_SCISSORS) || (b == MV_LIZARD);
      MV_PAPER:    r = (b == MV_ROCK)     || (b == MV_SPOCK);
      MV_SCISSORS: r = (b == MV_PAPER)    || (b == MV_LIZARD);
      MV_LIZARD:   r = (b == MV_PAPER)    || (b == MV_SPOCK);
      MV_SPOCK:    r = (b == MV_ROCK)     || (b == MV_SCISSORS);
`else
      MV_ROCK:     r = (b == MV_SCISSORS);
      MV_PAPER:    r = (b == MV_ROCK);
      MV_SCISSORS: r = (b == MV_PAPER);
`endif
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         p1_mv_q, p1_mv_d;
  logic [2:0]         p2_mv_q, p2_mv_d;
  logic               p1_held_d, p2_held_d;
  logic [1:0]         move_err_d;
  logic               p1_win_d, p2_win_d, tie_d;
  logic [SCORE_W-1:0] p1_score_d, p2_score_d;
  logic [ROUND_W-1:0] round_cnt_d;
  logic               match_done_d;
  logic [1:0]         match_winner_d;

  always_comb begin
    state_d        = state_q;
    p1_mv_d        = p1_mv_q;
    p2_mv_d        = p2_mv_q;
    p1_held_d      = p1_held;
    p2_held_d      = p2_held;
    move_err_d     = 2'b00;
    p1_win_d       = 1'b0;
    p2_win_d       = 1'b0;
    tie_d          = 1'b0;
    p1_score_d     = p1_score;
    p2_score_d     = p2_score;
    round_cnt_d    = round_cnt;
    match_done_d   = match_done;
    match_winner_d = match_winner;

    // new_match overrides whatever the FSM would have done this edge
    if (new_match) begin
      state_d        = S_WAIT;
      p1_mv_d        = 3'd0;
      p2_mv_d        = 3'd0;
      p1_held_d      = 1'b0;
      p2_held_d      = 1'b0;
      p1_score_d     = '0;
      p2_score_d     = '0;
      round_cnt_d    = '0;
      match_done_d   = 1'b0;
      match_winner_d = WIN_NONE;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (p1_valid && !p1_held) begin
            if (move_legal(p1_move)) begin
              p1_mv_d   = p1_move;
              p1_held_d = 1'b1;
            end else begin
              move_err_d[0] = 1'b1;
            end
          end
          if (p2_valid && !p2_held) begin
            if (move_legal(p2_move)) begin
              p2_mv_d   = p2_move;
              p2_held_d = 1'b1;
            end else begin
              move_err_d[1] = 1'b1;
            end
          end
          if (p1_held_d && p2_held_d) state_d = S_JUDGE;
        end

        S_JUDGE: begin
          p1_held_d   = 1'b0;
          p2_held_d   = 1'b0;
          round_cnt_d = round_cnt + ROUND_W'(1);
          if (beats(p1_mv_q, p2_mv_q)) begin
            p1_win_d   = 1'b1;
            p1_score_d = p1_score + SCORE_W'(1);
          end else if (beats(p2_mv_q, p1_mv_q)) begin
            p2_win_d   = 1'b1;
            p2_score_d = p2_score + SCORE_W'(1);
          end else begin
            tie_d = 1'b1;
          end

          // a match win outranks hitting the round limit on the same round
          if (p1_score_d == WINS_L) begin
            state_d        = S_DONE;
            match_done_d   = 1'b1;
            match_winner_d = WIN_P1;
          end else if (p2_score_d == WINS_L) begin
            state_d        = S_DONE;
            match_done_d   = 1'b1;
            match_winner_d = WIN_P2;
          end else if (round_cnt_d == ROUNDS_L) begin
            state_d        = S_DONE;
            match_done_d   = 1'b1;
            match_winner_d = WIN_DRAW;
          end else begin
            state_d = S_WAIT;
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT;
      p1_mv_q      <= 3'd0;
      p2_mv_q      <= 3'd0;
      p1_held      <= 1'b0;
      p2_held      <= 1'b0;
      move_err     <= 2'b00;
      round_p1_win <= 1'b0;
      round_p2_win <= 1'b0;
      round_tie    <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      round_cnt    <= '0;
      match_done   <= 1'b0;
      match_winner <= WIN_NONE;
    end else begin
      state_q      <= state_d;
      p1_mv_q      <= p1_mv_d;
      p2_mv_q      <= p2_mv_d;
      p1_held      <= p1_held_d;
      p2_held      <= p2_held_d;
      move_err     <= move_err_d;
      round_p1_win <= p1_win_d;
      round_p2_win <= p2_win_d;
      round_tie    <= tie_d;
      p1_score     <= p1_score_d;
      p2_score     <= p2_score_d;
      round_cnt    <= round_cnt_d;
      match_done   <= match_done_d;
      match_winner <= match_winner_d;
    end
  end

endmodule

// File: tb/tb_rps_match_referee.sv
// Directed plus randomized bench for rps_match_referee against a rule-table reference model.
// Honors LIZARD_SPOCK_EN the same way the design does.
module tb_rps_match_referee;

  localparam int WINS = 3;
  localparam int MAXR = 9;
  localparam int SW   = 4;
  localparam int RW   = 4;
`ifdef LIZARD_SPOCK_EN
  localparam int MAX_LEGAL = 5;
`else
  localparam int MAX_LEGAL = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    p1_move = 3'd0, p2_move = 3'd0;
  logic          p1_valid = 1'b0, p2_valid = 1'b0, new_match = 1'b0;
  logic          p1_held, p2_held;
  logic [1:0]    move_err;
  logic          round_p1_win, round_p2_win, round_tie;
  logic [SW-1:0] p1_score, p2_score;
  logic [RW-1:0] round_cnt;
  logic          match_done;
  logic [1:0]    match_winner;

  int vectors = 0;
  int miscompares = 0;

  rps_match_referee #(
    .WINS_TO_MATCH(WINS), .SCORE_W(SW), .MAX_ROUNDS(MAXR), .ROUND_W(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .p1_move(p1_move), .p1_valid(p1_valid),
    .p2_move(p2_move), .p2_valid(p2_valid),
    .new_match(new_match),
    .p1_held(p1_held), .p2_held(p2_held),
    .move_err(move_err),
    .round_p1_win(round_p1_win), .round_p2_win(round_p2_win), .round_tie(round_tie),
    .p1_score(p1_score), .p2_score(p2_score),
    .round_cnt(round_cnt),
    .match_done(match_done), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  // winner/loser pairs straight from the game rules
  int win_pairs [10][2] = '{'{1,3}, '{1,4}, '{2,1}, '{2,5}, '{3,2},
                            '{3,4}, '{4,2}, '{4,5}, '{5,1}, '{5,3}};

  // reference model state
  int  m_mv1, m_mv2, m_s1, m_s2, m_rc, m_win;
  bit  m_h1, m_h2, m_done, m_due;
  int  m_err, m_w1, m_w2, m_tie;

  function automatic bit rule_beats(int a, int b);
    for (int i = 0; i < 10; i++)
      if (win_pairs[i][0] == a && win_pairs[i][1] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_legal(int m);
    return (m >= 1) && (m <= MAX_LEGAL);
  endfunction

  task automatic model_clear();
    m_mv1 = 0; m_mv2 = 0; m_s1 = 0; m_s2 = 0; m_rc = 0; m_win = 0;
    m_h1 = 0; m_h2 = 0; m_done = 0; m_due = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_err = 0; m_w1 = 0; m_w2 = 0; m_tie = 0;
  endtask

  task automatic model_edge(input int a, input bit av, input int b, input bit bv, input bit nm);
    m_err = 0; m_w1 = 0; m_w2 = 0; m_tie = 0;
    if (nm) begin
      model_clear();
    end else if (m_done) begin
      // match over: inputs ignored
    end else if (m_due) begin
      m_due = 0; m_h1 = 0; m_h2 = 0; m_rc = m_rc + 1;
      if (rule_beats(m_mv1, m_mv2)) begin m_w1 = 1; m_s1 = m_s1 + 1; end
      else if (rule_beats(m_mv2, m_mv1)) begin m_w2 = 1; m_s2 = m_s2 + 1; end
      else m_tie = 1;
      if (m_s1 == WINS) begin m_done = 1; m_win = 1; end
      else if (m_s2 == WINS) begin m_done = 1; m_win = 2; end
      else if (m_rc == MAXR) begin m_done = 1; m_win = 3; end
    end else begin
      if (av && !m_h1) begin
        if (is_legal(a)) begin m_mv1 = a; m_h1 = 1; end else m_err = m_err + 1;
      end
      if (bv && !m_h2) begin
        if (is_legal(b)) begin m_mv2 = b; m_h2 = 1; end else m_err = m_err + 2;
      end
      if (m_h1 && m_h2) m_due = 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":p1_held"},      16'(p1_held),      16'(m_h1));
    check({tag, ":p2_held"},      16'(p2_held),      16'(m_h2));
    check({tag, ":move_err"},     16'(move_err),     16'(m_err));
    check({tag, ":round_p1_win"}, 16'(round_p1_win), 16'(m_w1));
    check({tag, ":round_p2_win"}, 16'(round_p2_win), 16'(m_w2));
    check({tag, ":round_tie"},    16'(round_tie),    16'(m_tie));
    check({tag, ":p1_score"},     16'(p1_score),     16'(m_s1));
    check({tag, ":p2_score"},     16'(p2_score),     16'(m_s2));
    check({tag, ":round_cnt"},    16'(round_cnt),    16'(m_rc));
    check({tag, ":match_done"},   16'(match_done),   16'(m_done));
    check({tag, ":match_winner"}, 16'(match_winner), 16'(m_win));
  endtask

  task automatic cycle(input int a, input bit av, input int b, input bit bv, input bit nm,
                       input string tag);
    p1_move = 3'(a); p1_valid = av; p2_move = 3'(b); p2_valid = bv; new_match = nm;
    @(posedge clk);
    model_edge(a, av, b, bv, nm);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int a, b;
    bit av, bv, nm;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset_winner_const", 16'(match_winner), 16'd0);
    reset = 1'b0;

    // both capture on one edge, judged on the next
    cycle(1, 1, 3, 1, 0, "cap_both");
    check("cap_both_h1_const", 16'({p1_held, p2_held}), 16'b11);
    cycle(0, 0, 0, 0, 0, "judge1");
    check("judge1_p1win_const", 16'(round_p1_win), 16'd1);
    check("judge1_rc_const", 16'(round_cnt), 16'd1);

    // first move stays locked
    cycle(2, 1, 0, 0, 0, "lock_paper");
    cycle(3, 1, 0, 0, 0, "ignore_relock");
`ifdef LIZARD_SPOCK_EN
    cycle(0, 0, 5, 1, 0, "p2_spock");
`else
    cycle(0, 0, 1, 1, 0, "p2_rock");
`endif
    cycle(0, 0, 0, 0, 0, "judge2");
    check("judge2_p1score_const", 16'(p1_score), 16'd2);
    check("judge2_p2score_const", 16'(p2_score), 16'd0);

    // illegal moves
    cycle(7, 1, 0, 0, 0, "err_p1");
    check("err_p1_const", 16'(move_err), 16'b01);
    cycle(0, 0, 0, 0, 0, "err_clear");
`ifndef LIZARD_SPOCK_EN
    cycle(0, 0, 4, 1, 0, "err_p2_lizard");
    check("err_p2_const", 16'(move_err), 16'b10);
`endif

    // p2 takes three rounds
    for (int r = 0; r < 3; r++) begin
      cycle(1, 1, 2, 1, 0, "p2_round_cap");
      cycle(0, 0, 0, 0, 0, "p2_round_judge");
    end
    check("p2_match_score_const", 16'(p2_score), 16'd3);
    check("p2_match_winner_const", 16'(match_winner), 16'b10);
    cycle(1, 1, 2, 1, 0, "done_ignore");
    cycle(7, 1, 0, 1, 0, "done_no_err");

    // nine ties reach the round limit
    cycle(0, 0, 0, 0, 1, "new_match1");
    for (int r = 0; r < MAXR; r++) begin
      cycle(2, 1, 2, 1, 0, "tie_cap");
      cycle(0, 0, 0, 0, 0, "tie_judge");
    end
    check("draw_rc_const", 16'(round_cnt), 16'd9);
    check("draw_winner_const", 16'(match_winner), 16'b11);
    cycle(0, 0, 0, 0, 1, "new_match2");
    cycle(3, 1, 2, 1, 0, "after_nm_cap");
    cycle(0, 0, 0, 0, 0, "after_nm_judge");

    // async reset mid-round
    cycle(2, 1, 0, 0, 0, "pre_rst_hold");
    async_reset("rst_mid_round");

    // new_match on the edge of the second capture
    cycle(1, 1, 0, 0, 0, "nm_race_a");
    cycle(0, 0, 3, 1, 1, "nm_race_b");
    cycle(0, 0, 0, 0, 0, "nm_race_quiet");
    check("nm_race_pulse_const", 16'({round_p1_win, round_p2_win, round_tie}), 16'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a  = int'($urandom_range(0, 7));
      b  = int'($urandom_range(0, 7));
      av = ($urandom_range(0, 9) < 6);
      bv = ($urandom_range(0, 9) < 6);
      nm = ($urandom_range(0, 59) == 0);
      cycle(a, av, b, bv, nm, "rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
